// File: rtl/fifo_rd_packer.sv
// FIFO read-side packer: pops WIDTH-bit words and groups PACK of them into one
// wide valid/ready beat, with a flush that emits a partially filled beat.
module fifo_rd_packer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PACK  = 4,
    localparam int unsigned CW   = $clog2(PACK + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty_i,
    output logic                  rd_en_o,
    input  logic [WIDTH-1:0]      rd_data_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WIDTH*PACK-1:0] out_data_o,
    output logic [CW-1:0]         out_cnt_o
);

    localparam logic [CW-1:0] PACK_CNT = CW'(PACK);
    localparam logic [CW:0]   PACK_OCC = (CW + 1)'(PACK);

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]                  state;
    logic [0:0]                  state_next;
    logic                        flush_pend;
    logic                        flush_pend_next;
    logic [PACK-1:0][WIDTH-1:0]  acc;
    logic [CW-1:0]               acc_cnt;
    logic [CW-1:0]               acc_cnt_eff;
    logic [CW:0]                 occupancy;
    logic                        inflight;
    logic                        out_free;
    logic                        full_xfer;
    logic                        flush_xfer;
    logic                        transfer;
    logic [WIDTH*PACK-1:0]       beat_data;

    // Transfer decision and FIFO read enable; a word still in flight counts
    // against accumulator space so acc never overflows.
    always_comb begin
        out_free    = !out_valid_o || out_ready_i;
        full_xfer   = (state == FILL) && (acc_cnt == PACK_CNT) && out_free;
        flush_xfer  = (state == FLUSH) && !inflight && (acc_cnt != '0) && out_free;
        transfer    = full_xfer || flush_xfer;
        acc_cnt_eff = transfer ? '0 : acc_cnt;
        occupancy   = {1'b0, acc_cnt_eff} + (CW + 1)'(inflight);
        rd_en_o     = !rst && !empty_i && (state == FILL) && (occupancy < PACK_OCC);
    end

    // Lanes at or above acc_cnt may hold stale words from an earlier beat.
    always_comb begin
        beat_data = '0;
        for (int unsigned i = 0; i < PACK; i++) begin
            if (CW'(i) < acc_cnt) begin
                beat_data[i*WIDTH +: WIDTH] = acc[i];
            end
        end
    end

    // Flush FSM: block new reads, let the last read land, then emit what is held.
    always_comb begin
        state_next      = state;
        flush_pend_next = flush_pend;
        if (state == FILL) begin
            if (flush_i || flush_pend) begin
                state_next      = FLUSH;
                flush_pend_next = 1'b1;
            end
        end else begin
            if (!inflight && ((acc_cnt == '0) || out_free)) begin
                state_next      = FILL;
                flush_pend_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_next;
            flush_pend <= flush_pend_next;
        end
    end

    // Capture and transfer never coincide: a full acc implies nothing in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            acc_cnt  <= '0;
        end else begin
            inflight <= rd_en_o;
            if (transfer) begin
                acc_cnt <= '0;
            end else if (inflight) begin
                acc_cnt <= acc_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < PACK; i++) begin
            if (inflight && (acc_cnt == CW'(i))) begin
                acc[i] <= rd_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_cnt_o   <= '0;
        end else if (transfer) begin
            out_valid_o <= 1'b1;
            out_data_o  <= beat_data;
            out_cnt_o   <= acc_cnt;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: directed scenarios plus a randomized run
// against a word-stream reference model with a FIFO model driving the DUT.
module tb_fifo_rd_packer;

    localparam int unsigned W  = 4;
    localparam int unsigned P  = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned DW = W * P;

    logic          clk = 1'b0;
    logic          rst;
    logic          empty_i;
    logic          rd_en_o;
    logic [W-1:0]  rd_data_i;
    logic          flush_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [CW-1:0] out_cnt_o;

    fifo_rd_packer #(.WIDTH(W), .PACK(P)) dut (
        .clk         (clk),
        .rst         (rst),
        .empty_i     (empty_i),
        .rd_en_o     (rd_en_o),
        .rd_data_i   (rd_data_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_cnt_o   (out_cnt_o)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0]  fifo_q[$];
    logic          s_rd, s_valid, s_ready, s_flush, s_empty, s_popped;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_cnt;
    logic [W-1:0]  s_word;

    // One clock: sample at negedge, then act as a 1-cycle-latency FIFO after posedge.
    task automatic cycle();
        @(negedge clk);
        s_rd    = rd_en_o;
        s_valid = out_valid_o;
        s_ready = out_ready_i;
        s_flush = flush_i;
        s_empty = empty_i;
        s_data  = out_data_o;
        s_cnt   = out_cnt_o;
        @(posedge clk);
        #1;
        s_popped = 1'b0;
        if (s_rd && fifo_q.size() > 0) begin
            s_word    = fifo_q.pop_front();
            rd_data_i = s_word;
            s_popped  = 1'b1;
        end else begin
            rd_data_i = W'($urandom);
        end
        empty_i = (fifo_q.size() == 0);
        flush_i = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] w);
        fifo_q.push_back(w);
        empty_i = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        fifo_q.delete();
        empty_i     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        empty_i     = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        rd_data_i   = '0;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if ({rd_en_o, out_valid_o, out_data_o, out_cnt_o} !== '0)
                $display("FAIL reset_hold: got rd=%b v=%b d=%h c=%0d want all 0",
                         rd_en_o, out_valid_o, out_data_o, out_cnt_o);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        empty_i = 1'b1;
    endtask

    task automatic test_single_beat();
        do_reset();
        for (int i = 1; i <= 4; i++) load(W'(i));
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_total++;
            if (s_rd !== (k < 4)) $display("FAIL single_rd cyc%0d: got %b want %b", k, s_rd, (k < 4));
            else n_pass++;
            n_total++;
            if (s_valid !== (k == 6)) $display("FAIL single_valid cyc%0d: got %b want %b", k, s_valid, (k == 6));
            else n_pass++;
            if (k == 6) begin
                n_total++;
                if (s_data !== 16'h4321 || s_cnt !== 3'd4)
                    $display("FAIL single_beat: got %h/%0d want 4321/4", s_data, s_cnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int rd_cnt;
        do_reset();
        out_ready_i = 1'b0;
        for (int i = 1; i <= 10; i++) load(W'(i));
        rd_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (s_rd) rd_cnt++;
            if (s_valid) begin
                n_total++;
                if (s_data !== 16'h4321 || s_cnt !== 3'd4)
                    $display("FAIL bp_hold cyc%0d: got %h/%0d want 4321/4", k, s_data, s_cnt);
                else n_pass++;
            end
        end
        n_total++;
        if (rd_cnt != 8) $display("FAIL bp_reads: got %0d want 8", rd_cnt);
        else n_pass++;
        out_ready_i = 1'b1;
        cycle();
        n_total++;
        if (!s_valid || s_data !== 16'h4321) $display("FAIL bp_beat1: got v=%b %h want 1 4321", s_valid, s_data);
        else n_pass++;
        cycle();
        n_total++;
        if (!s_valid || s_data !== 16'h8765 || s_cnt !== 3'd4)
            $display("FAIL bp_beat2: got v=%b %h/%0d want 1 8765/4", s_valid, s_data, s_cnt);
        else n_pass++;
    endtask

    task automatic test_partial_flush();
        int beats;
        logic early;
        do_reset();
        load(4'hA); load(4'hB); load(4'hC);
        early = 1'b0;
        repeat (5) begin
            cycle();
            if (s_valid) early = 1'b1;
        end
        n_total++;
        if (early) $display("FAIL pflush_early: got beat before flush want none");
        else n_pass++;
        flush_i = 1'b1;
        beats = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (s_valid) begin
                beats++;
                n_total++;
                if (s_data !== 16'h0CBA || s_cnt !== 3'd3)
                    $display("FAIL pflush_beat: got %h/%0d want 0cba/3", s_data, s_cnt);
                else n_pass++;
            end
        end
        n_total++;
        if (beats != 1) $display("FAIL pflush_count: got %0d want 1", beats);
        else n_pass++;
    endtask

    task automatic test_flush_corners();
        int beats;
        do_reset();
        flush_i = 1'b1;
        beats = 0;
        repeat (6) begin
            cycle();
            if (s_valid) beats++;
        end
        n_total++;
        if (beats != 0) $display("FAIL flush_empty: got %0d beats want 0", beats);
        else n_pass++;
        load(4'h5); load(4'h6);
        cycle();
        n_total++;
        if (s_rd !== 1'b1) $display("FAIL flush_rd0: got %b want 1", s_rd);
        else n_pass++;
        flush_i = 1'b1;
        cycle();
        n_total++;
        if (s_rd !== 1'b1) $display("FAIL flush_rd_same_cycle: got %b want 1", s_rd);
        else n_pass++;
        beats = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (s_valid) begin
                beats++;
                n_total++;
                if (s_data !== 16'h0065 || s_cnt !== 3'd2)
                    $display("FAIL flush_same_beat: got %h/%0d want 0065/2", s_data, s_cnt);
                else n_pass++;
            end
        end
        n_total++;
        if (beats != 1) $display("FAIL flush_same_count: got %0d want 1", beats);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int beats;
        do_reset();
        out_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) load(W'(i));
        repeat (14) cycle();
        n_total++;
        if (s_valid !== 1'b1) $display("FAIL rmid_pre: got valid=%b want 1", s_valid);
        else n_pass++;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({rd_en_o, out_valid_o, out_data_o, out_cnt_o} !== '0)
            $display("FAIL rmid_async: got rd=%b v=%b d=%h c=%0d want all 0",
                     rd_en_o, out_valid_o, out_data_o, out_cnt_o);
        else n_pass++;
        fifo_q.delete();
        empty_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready_i = 1'b1;
        load(4'h9); load(4'hA); load(4'hB); load(4'hC);
        beats = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (s_valid) begin
                beats++;
                n_total++;
                if (s_data !== 16'hCBA9 || s_cnt !== 3'd4)
                    $display("FAIL rmid_beat: got %h/%0d want cba9/4", s_data, s_cnt);
                else n_pass++;
            end
        end
        n_total++;
        if (beats != 1) $display("FAIL rmid_count: got %0d want 1", beats);
        else n_pass++;
    endtask

    // Reference: popped words form a stream; a beat closes at P words or at a flush.
    task automatic test_random();
        logic [W-1:0]  pending[$];
        logic [DW-1:0] exp_data[$];
        logic [CW-1:0] exp_cnt[$];
        logic [DW-1:0] b, prev_data;
        logic [CW-1:0] prev_cnt;
        logic          prev_valid, prev_ready;
        int            since_flush;
        do_reset();
        prev_valid  = 1'b0;
        prev_ready  = 1'b1;
        prev_data   = '0;
        prev_cnt    = '0;
        since_flush = 0;
        for (int k = 0; k < 1600; k++) begin
            if (k < 1500) begin
                if ($urandom_range(0, 2) != 0 && fifo_q.size() < 6) load(W'($urandom));
                out_ready_i = ((k / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                if (exp_data.size() == 0 && since_flush >= 4 && $urandom_range(0, 19) == 0) begin
                    flush_i = 1'b1;
                    since_flush = 0;
                end else begin
                    since_flush++;
                end
            end else begin
                out_ready_i = 1'b1;
                if (k == 1530) flush_i = 1'b1;
            end
            cycle();
            n_total++;
            if (s_rd && s_empty) $display("FAIL rnd_rd_empty cyc%0d: got rd=1 want 0", k);
            else n_pass++;
            if (s_popped) pending.push_back(s_word);
            if (pending.size() == P || (s_flush && pending.size() != 0)) begin
                b = '0;
                for (int i = 0; i < pending.size(); i++) b[i*W +: W] = pending[i];
                exp_data.push_back(b);
                exp_cnt.push_back(CW'(pending.size()));
                pending.delete();
            end
            if (prev_valid && !prev_ready) begin
                n_total++;
                if (!s_valid || s_data !== prev_data || s_cnt !== prev_cnt)
                    $display("FAIL rnd_stable cyc%0d: got v=%b %h/%0d want 1 %h/%0d",
                             k, s_valid, s_data, s_cnt, prev_data, prev_cnt);
                else n_pass++;
            end
            if (s_valid && s_ready) begin
                n_total++;
                if (exp_data.size() == 0) begin
                    $display("FAIL rnd_extra_beat cyc%0d: got %h/%0d want no beat", k, s_data, s_cnt);
                end else begin
                    if (s_data !== exp_data[0] || s_cnt !== exp_cnt[0])
                        $display("FAIL rnd_beat cyc%0d: got %h/%0d want %h/%0d",
                                 k, s_data, s_cnt, exp_data[0], exp_cnt[0]);
                    else n_pass++;
                    void'(exp_data.pop_front());
                    void'(exp_cnt.pop_front());
                end
            end
            prev_valid = s_valid;
            prev_ready = s_ready;
            prev_data  = s_data;
            prev_cnt   = s_cnt;
        end
        n_total++;
        if (exp_data.size() != 0 || pending.size() != 0 || fifo_q.size() != 0)
            $display("FAIL rnd_drain: got exp=%0d pend=%0d fifo=%0d want 0/0/0",
                     exp_data.size(), pending.size(), fifo_q.size());
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_partial_flush();
        test_flush_corners();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the synchronous FIFO. It pops WIDTH-bit words from the FIFO read port and packs PACK consecutive words into one wide output beat, presented on a valid/ready interface. A flush input forces out a partially filled beat. It sits directly downstream of the FIFO and drives the FIFO's read enable.

## Interface

- WIDTH, 4: FIFO word width in bits.
- PACK, 4: number of words per output beat; legal range is PACK ≥ 2.
- CW, $clog2(PACK+1): width of the word-count output (derived; not overridden).

- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- empty_i  in  1  FIFO empty flag.
- rd_en_o  out  1  FIFO read enable.
- rd_data_i  in  WIDTH  FIFO read data. Valid the cycle after rd_en_o is high.
- flush_i  in  1  single-cycle request to emit the partially filled beat.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts the beat.
- out_data_o  out  WIDTH*PACK  packed beat. The first word popped occupies bits [WIDTH-1:0].
- out_cnt_o  out  CW  number of valid words in the beat (1..PACK).

## Operation

**Registers**
- acc: PACK×WIDTH word accumulator.
- acc_cnt: 0..PACK.
- inflight: rd_en_o delayed one cycle.
- flush_pend.
- Output register: out_valid_o, out_data_o, out_cnt_o.
- FSM state: FILL or FLUSH.

**Read enable**
- rd_en_o = !rst && !empty_i && state==FILL && (acc_cnt_eff + inflight < PACK).
- acc_cnt_eff is 0 if a transfer occurs this cycle; otherwise it equals acc_cnt.
- rd_en_o is never high while empty_i is high or while rst is high.

**Capture**
- When inflight is high, rd_data_i is written to lane acc_cnt and acc_cnt increments.

**Transfer (accumulator to output register)**
- Output-free condition: out_valid_o==0 or out_ready_i==1.
- Full-beat transfer happens when acc_cnt==PACK and the output is free:
  - out_data_o is loaded from acc.
  - out_cnt_o is set to PACK.
  - out_valid_o is set to 1.
  - acc_cnt is set to 0.
- Capture and transfer never coincide, because acc_cnt==PACK implies inflight==0.
- If out_ready_i is high and no transfer occurs, out_valid_o clears to 0.

**FSM**
- FILL goes to FLUSH when flush_i is high, or when flush_pend is set.
- In FLUSH, no new reads are issued. The block waits for inflight==0, then:
  - acc_cnt==0: return to FILL and emit no beat.
  - acc_cnt>0 and output free: transfer a partial beat.
    - out_cnt_o = acc_cnt.
    - Unfilled lanes of out_data_o are driven 0.
    - acc_cnt is set to 0 and the FSM returns to FILL.
  - Output not free: stay in FLUSH.
- flush_i asserted while already in FLUSH is absorbed and has no extra effect.

## Timing

- Reset (asynchronous, takes effect immediately) clears:
  - out_valid_o, out_data_o, out_cnt_o, acc_cnt, inflight and flush_pend all go to 0.
  - State goes to FILL.
  - rd_en_o goes to 0.
- An in-flight FIFO word is discarded on reset.
- FIFO read latency is 1 cycle; the block depends on this.
- Latency: with the FIFO non-empty and out_ready_i held high, the first rd_en_o is in cycle 0 and out_valid_o rises in cycle PACK+2.
- Sustained throughput is PACK words per PACK+1 cycles. There is one bubble cycle per beat, in the cycle where acc_cnt+inflight==PACK.
- Backpressure behaviour:
  - The output register holds one beat and acc holds a second.
  - Reads stop when both are full.
  - No word is ever dropped or duplicated.
- The output is stable while out_valid_o && !out_ready_i: data and count do not change.
- When out_ready_i is high and acc is full, a back-to-back beat appears the next cycle.
- Simultaneous flush_i and rd_en_o: the read issued that cycle is still captured and included in the flushed beat.

## Test plan

- **Reset:** hold rst=1 with empty_i=0 and toggle clk. Require rd_en_o=0, out_valid_o=0, out_data_o=0 and out_cnt_o=0. Assert rst asynchronously mid-cycle and require the outputs to clear without a clock edge.
- **Single beat (WIDTH=4, PACK=4):** FIFO preloaded with 1,2,3,4, out_ready_i=1. Require rd_en_o high in cycles 0–3, out_valid_o high only in cycle 6, out_data_o=16'h4321 and out_cnt_o=4.
- **Backpressure:** FIFO holds 1..8, out_ready_i=0. Require:
  - out_data_o=16'h4321 held stable.
  - Exactly 8 rd_en_o pulses, then rd_en_o stays 0.
  - After out_ready_i rises: beats 16'h4321 then 16'h8765 on consecutive cycles.
- **Partial flush:** pop A, B, C, then empty_i=1 and pulse flush_i. Require one beat with out_data_o=16'h0CBA and out_cnt_o=3.
- **Flush corner cases:**
  - flush_i with acc_cnt=0 gives no beat.
  - flush_i in the same cycle as the 2nd rd_en_o (data 5,6) gives a beat of 16'h0065 with out_cnt_o=2.
- **Reset mid-operation:** assert rst while out_valid_o=1 and acc_cnt=2. After release, feed 9,A,B,C and require a beat of 16'hCBA9 with no stale words.
